// File: rtl/alu_result_stage_27x18.sv
// Registered P stage for the 27/18-bit SIMD ALU: result/carry capture, per-lane
// pattern detect, non-SIMD overflow/underflow flags and a saturating load counter.
module alu_result_stage_27x18 #(
    parameter int WIDTH_LO         = 27,
    parameter int WIDTH_HI         = 18,
    parameter int AUTORESET_PATDET = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         CEP,
    input  logic                         RSTP,
    input  logic                         valid_in,
    input  logic                         USE_SIMD,
    input  logic [WIDTH_LO+WIDTH_HI-1:0] S,
    input  logic [3:0]                   result_SIMD_carry_out,
    input  logic [WIDTH_LO+WIDTH_HI-1:0] PATTERN,
    input  logic [WIDTH_LO+WIDTH_HI-1:0] MASK,
    output logic [WIDTH_LO+WIDTH_HI-1:0] P,
    output logic [WIDTH_LO+WIDTH_HI-1:0] P_FB,
    output logic [3:0]                   CARRYOUT,
    output logic                         valid_out,
    output logic [1:0]                   PATTERNDETECT,
    output logic [1:0]                   PATTERNBDETECT,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW,
    output logic [15:0]                  ACC_COUNT
);

    localparam int W = WIDTH_LO + WIDTH_HI;
    localparam logic [W-1:0] LO_SEL = {{WIDTH_HI{1'b0}}, {WIDTH_LO{1'b1}}};
    localparam logic [W-1:0] HI_SEL = ~LO_SEL;

    // True when every selected, unmasked bit of v equals pat.
    function automatic logic lane_match(input logic [W-1:0] v, input logic [W-1:0] pat,
                                        input logic [W-1:0] msk, input logic [W-1:0] sel);
        return &((v ~^ pat) | msk | ~sel);
    endfunction

    logic [W-1:0]  p_q, p_d;
    logic [3:0]    co_q, co_d;
    logic          valid_q, valid_d;
    logic [1:0]    pd_q, pd_d, pbd_q, pbd_d;
    logic          pd_past_q, pd_past_d, pbd_past_q, pbd_past_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          mode_q, mode_d;

    logic          autoreset_s;
    logic [W-1:0]  ld_s;
    logic [1:0]    pd_new_s, pbd_new_s;
    logic          pd_lo_s, pd_hi_s, pbd_lo_s, pbd_hi_s;
    logic          pd_past_new_s, pbd_past_new_s;

    // Value actually loaded on a load edge and the detect results derived from it.
    always_comb begin
        autoreset_s = (AUTORESET_PATDET != 0) && (mode_q ? (&pd_q) : pd_q[0]);
        ld_s        = autoreset_s ? {W{1'b0}} : S;
        pd_lo_s     = lane_match(ld_s, PATTERN, MASK, LO_SEL);
        pd_hi_s     = lane_match(ld_s, PATTERN, MASK, HI_SEL);
        pbd_lo_s    = lane_match(ld_s, ~PATTERN, MASK, LO_SEL);
        pbd_hi_s    = lane_match(ld_s, ~PATTERN, MASK, HI_SEL);
        if (USE_SIMD) begin
            pd_new_s  = {pd_hi_s, pd_lo_s};
            pbd_new_s = {pbd_hi_s, pbd_lo_s};
        end else begin
            pd_new_s  = {2{pd_lo_s & pd_hi_s}};
            pbd_new_s = {2{pbd_lo_s & pbd_hi_s}};
        end
        // A mode switch discards history so the first load in the new mode cannot flag.
        pd_past_new_s  = (USE_SIMD == mode_q) ? pd_q[0]  : 1'b0;
        pbd_past_new_s = (USE_SIMD == mode_q) ? pbd_q[0] : 1'b0;
    end

    // Next-state selection: RSTP, then CEP hold, then idle, then load.
    always_comb begin
        p_d        = p_q;
        co_d       = co_q;
        valid_d    = valid_q;
        pd_d       = pd_q;
        pbd_d      = pbd_q;
        pd_past_d  = pd_past_q;
        pbd_past_d = pbd_past_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        if (RSTP) begin
            p_d        = {W{1'b0}};
            co_d       = 4'd0;
            valid_d    = 1'b0;
            pd_d       = 2'b00;
            pbd_d      = 2'b00;
            pd_past_d  = 1'b0;
            pbd_past_d = 1'b0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            cnt_d      = 16'd0;
        end else if (!CEP) begin
            valid_d = valid_q;
        end else if (!valid_in) begin
            valid_d = 1'b0;
        end else begin
            p_d        = ld_s;
            valid_d    = 1'b1;
            mode_d     = USE_SIMD;
            pd_d       = pd_new_s;
            pbd_d      = pbd_new_s;
            pd_past_d  = pd_past_new_s;
            pbd_past_d = pbd_past_new_s;
            ovf_d      = !USE_SIMD && pd_past_new_s  && !pd_new_s[0] && !pbd_new_s[0];
            unf_d      = !USE_SIMD && pbd_past_new_s && !pd_new_s[0] && !pbd_new_s[0];
            if (autoreset_s) begin
                co_d  = 4'd0;
                cnt_d = 16'd0;
            end else begin
                // Lane-0 carries are internal to the 45-bit add when not in SIMD mode.
                co_d  = USE_SIMD ? result_SIMD_carry_out : {result_SIMD_carry_out[3:2], 2'b00};
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q        <= {W{1'b0}};
            co_q       <= 4'd0;
            valid_q    <= 1'b0;
            pd_q       <= 2'b00;
            pbd_q      <= 2'b00;
            pd_past_q  <= 1'b0;
            pbd_past_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cnt_q      <= 16'd0;
            mode_q     <= 1'b0;
        end else begin
            p_q        <= p_d;
            co_q       <= co_d;
            valid_q    <= valid_d;
            pd_q       <= pd_d;
            pbd_q      <= pbd_d;
            pd_past_q  <= pd_past_d;
            pbd_past_q <= pbd_past_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
        end
    end

    assign P              = p_q;
    assign P_FB           = p_q;
    assign CARRYOUT       = co_q;
    assign valid_out      = valid_q;
    assign PATTERNDETECT  = pd_q;
    assign PATTERNBDETECT = pbd_q;
    assign OVERFLOW       = ovf_q;
    assign UNDERFLOW      = unf_q;
    assign ACC_COUNT      = cnt_q;

endmodule

// File: tb/tb_alu_result_stage_27x18.sv
// Self-checking bench: two instances (autoreset off/on) driven in parallel and
// compared every cycle against a behavioural model, plus directed spot checks.
module tb_alu_result_stage_27x18;

    logic        clk = 1'b0;
    logic        reset, CEP, RSTP, valid_in, USE_SIMD;
    logic [44:0] S, PATTERN, MASK;
    logic [3:0]  cin;

    logic [44:0] P0, PFB0, P1, PFB1;
    logic [3:0]  CO0, CO1;
    logic        V0, V1, OV0, OV1, UN0, UN1;
    logic [1:0]  PD0, PD1, PBD0, PBD1;
    logic [15:0] CNT0, CNT1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_result_stage_27x18 #(.AUTORESET_PATDET(0)) dut0 (
        .clk(clk), .reset(reset), .CEP(CEP), .RSTP(RSTP), .valid_in(valid_in),
        .USE_SIMD(USE_SIMD), .S(S), .result_SIMD_carry_out(cin), .PATTERN(PATTERN),
        .MASK(MASK), .P(P0), .P_FB(PFB0), .CARRYOUT(CO0), .valid_out(V0),
        .PATTERNDETECT(PD0), .PATTERNBDETECT(PBD0), .OVERFLOW(OV0), .UNDERFLOW(UN0),
        .ACC_COUNT(CNT0));

    alu_result_stage_27x18 #(.AUTORESET_PATDET(1)) dut1 (
        .clk(clk), .reset(reset), .CEP(CEP), .RSTP(RSTP), .valid_in(valid_in),
        .USE_SIMD(USE_SIMD), .S(S), .result_SIMD_carry_out(cin), .PATTERN(PATTERN),
        .MASK(MASK), .P(P1), .P_FB(PFB1), .CARRYOUT(CO1), .valid_out(V1),
        .PATTERNDETECT(PD1), .PATTERNBDETECT(PBD1), .OVERFLOW(OV1), .UNDERFLOW(UN1),
        .ACC_COUNT(CNT1));

    // Reference state, index 0 = no autoreset, 1 = autoreset.
    logic [44:0] m_p   [2];
    logic [3:0]  m_co  [2];
    logic [1:0]  m_pd  [2];
    logic [1:0]  m_pbd [2];
    logic        m_v [2], m_pdp [2], m_pbdp [2], m_ov [2], m_un [2], m_mode [2];
    int          m_cnt [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p[k] = '0; m_co[k] = '0; m_pd[k] = '0; m_pbd[k] = '0; m_v[k] = 1'b0;
            m_pdp[k] = 1'b0; m_pbdp[k] = 1'b0; m_ov[k] = 1'b0; m_un[k] = 1'b0;
            m_mode[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_update(input int k);
        logic [44:0] ld, diff, diffb;
        logic [1:0]  npd, npbd;
        logic        whole, past_ok;
        if (RSTP) begin
            m_p[k] = '0; m_co[k] = '0; m_pd[k] = '0; m_pbd[k] = '0; m_v[k] = 1'b0;
            m_pdp[k] = 1'b0; m_pbdp[k] = 1'b0; m_ov[k] = 1'b0; m_un[k] = 1'b0; m_cnt[k] = 0;
        end else if (CEP && !valid_in) begin
            m_v[k] = 1'b0;
        end else if (CEP) begin
            whole = m_mode[k] ? (m_pd[k] == 2'b11) : m_pd[k][0];
            if (k == 1 && whole) begin
                ld = '0; m_co[k] = '0; m_cnt[k] = 0;
            end else begin
                ld = S;
                m_co[k] = USE_SIMD ? cin : (cin & 4'b1100);
                if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
            end
            diff  = (ld ^ PATTERN) & ~MASK;
            diffb = (ld ^ ~PATTERN) & ~MASK;
            if (USE_SIMD) begin
                npd  = {diff[44:27] == 0, diff[26:0] == 0};
                npbd = {diffb[44:27] == 0, diffb[26:0] == 0};
            end else begin
                npd  = {2{diff == 0}};
                npbd = {2{diffb == 0}};
            end
            past_ok   = (USE_SIMD == m_mode[k]);
            m_pdp[k]  = past_ok && m_pd[k][0];
            m_pbdp[k] = past_ok && m_pbd[k][0];
            m_ov[k]   = !USE_SIMD && m_pdp[k]  && !npd[0] && !npbd[0];
            m_un[k]   = !USE_SIMD && m_pbdp[k] && !npd[0] && !npbd[0];
            m_p[k] = ld; m_pd[k] = npd; m_pbd[k] = npbd; m_v[k] = 1'b1; m_mode[k] = USE_SIMD;
        end
    endtask

    task automatic check_dut(input int k, input logic [44:0] p, input logic [44:0] pfb,
                             input logic [3:0] co, input logic v, input logic [1:0] pd,
                             input logic [1:0] pbd, input logic ov, input logic un,
                             input logic [15:0] cnt);
        chk($sformatf("dut%0d.P", k), p, m_p[k]);
        chk($sformatf("dut%0d.P_FB", k), pfb, m_p[k]);
        chk($sformatf("dut%0d.CARRYOUT", k), co, m_co[k]);
        chk($sformatf("dut%0d.valid_out", k), v, m_v[k]);
        chk($sformatf("dut%0d.PATTERNDETECT", k), pd, m_pd[k]);
        chk($sformatf("dut%0d.PATTERNBDETECT", k), pbd, m_pbd[k]);
        chk($sformatf("dut%0d.OVERFLOW", k), ov, m_ov[k]);
        chk($sformatf("dut%0d.UNDERFLOW", k), un, m_un[k]);
        chk($sformatf("dut%0d.ACC_COUNT", k), cnt, m_cnt[k][15:0]);
    endtask

    // One clock edge; inputs are already stable, outputs sampled 1 time unit later.
    task automatic step(input bit do_check);
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else begin
            model_update(0);
            model_update(1);
        end
        if (do_check) begin
            check_dut(0, P0, PFB0, CO0, V0, PD0, PBD0, OV0, UN0, CNT0);
            check_dut(1, P1, PFB1, CO1, V1, PD1, PBD1, OV1, UN1, CNT1);
        end
    endtask

    task automatic load(input logic [44:0] s_val);
        CEP = 1'b1; RSTP = 1'b0; valid_in = 1'b1; S = s_val;
        step(1'b1);
    endtask

    initial begin
        logic [63:0] r64;
        int sel;
        reset = 1'b1; CEP = 1'b1; RSTP = 1'b0; valid_in = 1'b1; USE_SIMD = 1'b0;
        S = 45'h1234; cin = 4'hF; PATTERN = 45'h1; MASK = '0;
        model_reset();

        // Outputs stay cleared while reset is held, even with a pending load.
        step(1'b1);
        step(1'b1);
        chk("reset_P", P0, 64'h0);
        reset = 1'b0;
        step(1'b1);
        chk("first_load_P", P0, 64'h1234);
        chk("first_load_carry_nonsimd", CO0, 64'hC);

        // CEP low holds everything while S changes.
        CEP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            S = 45'h100 + 45'(i);
            step(1'b1);
        end
        chk("cep_hold_P", P0, 64'h1234);
        chk("cep_hold_cnt", CNT0, 64'h1);

        // RSTP wins over CEP=0.
        RSTP = 1'b1;
        step(1'b1);
        chk("rstp_P", P0, 64'h0);
        chk("rstp_cnt", CNT0, 64'h0);

        // SIMD lane detect.
        USE_SIMD = 1'b1; PATTERN = '0; MASK = '0; cin = 4'h5;
        load({18'h0, 27'h5});
        chk("simd_pd_hi_only", PD0, 64'h2);
        load(45'h0);
        chk("simd_pd_both", PD0, 64'h3);

        // Non-SIMD overflow: only bits 44:43 compared, value leaves the pattern upward.
        USE_SIMD = 1'b0; MASK = 45'h07FF_FFFF_FFFF;
        load(45'h0);
        load(45'h0);
        load(45'h1000_0000_0000);
        chk("overflow_flag", OV0, 64'h1);
        chk("overflow_no_underflow", UN0, 64'h0);
        load(45'h1FFF_FFFF_FFFF);
        load(45'h0800_0000_0000);
        chk("underflow_flag", UN0, 64'h1);

        // Autoreset: match then load 7.
        CEP = 1'b1; RSTP = 1'b1; valid_in = 1'b0;
        step(1'b1);
        PATTERN = 45'h55; MASK = '0;
        load(45'h55);
        load(45'h7);
        chk("autoreset_P", P1, 64'h0);
        chk("autoreset_cnt", CNT1, 64'h0);
        chk("no_autoreset_P", P0, 64'h7);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            CEP      = ($urandom_range(0, 9) != 0);
            RSTP     = ($urandom_range(0, 49) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) USE_SIMD = ~USE_SIMD;
            if ($urandom_range(0, 31) == 0) begin
                r64 = {$urandom(), $urandom()};
                PATTERN = r64[44:0];
                r64 = {$urandom(), $urandom()};
                MASK = ($urandom_range(0, 1) == 0) ? (45'h07FF_FFFF_FFFF | r64[44:0] & 45'h1)
                                                   : r64[44:0];
            end
            cin = 4'($urandom_range(0, 15));
            r64 = {$urandom(), $urandom()};
            sel = $urandom_range(0, 4);
            case (sel)
                0: S = PATTERN;
                1: S = ~PATTERN;
                2: S = PATTERN ^ (45'(1) << $urandom_range(0, 44));
                3: S = '0;
                default: S = r64[44:0];
            endcase
            step(1'b1);
        end

        // Counter saturation.
        USE_SIMD = 1'b0; PATTERN = 45'h1; MASK = '0; S = '0;
        CEP = 1'b1; RSTP = 1'b1; valid_in = 1'b0;
        step(1'b1);
        RSTP = 1'b0; valid_in = 1'b1;
        for (int i = 0; i < 70000; i++) step(i == 65534 || i == 69999);
        chk("counter_saturated", CNT0, 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
